// File: rtl/tcm_pmem_pkg.sv
// Shared types and parameter limits for the TCM port-memory arbiter.
package tcm_pmem_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        CORE = 2'b01,
        AXI  = 2'b10
    } src_t;

    localparam int READ_LAT_MIN   = 1;
    localparam int READ_LAT_MAX   = 4;
    localparam int STARVE_MIN     = 1;
    localparam int STARVE_MAX_LIM = 255;
    localparam int STARVE_CNT_W   = 8;

endpackage

// File: rtl/tcm_pmem_rd_pipe.sv
// Read-return tag pipeline: replays each read's source tag READ_LAT cycles later.
module tcm_pmem_rd_pipe
    import tcm_pmem_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_rd,
    input  src_t i_tag,
    output logic o_rvalid,
    output src_t o_rsrc
);

    src_t r_tag [READ_LAT];

    // A NONE tag marks an empty slot, so no separate valid bit is carried.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_tag[i] <= NONE;
            end
        end else begin
            r_tag[0] <= i_rd ? i_tag : NONE;
            for (int i = 1; i < READ_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_rvalid = (r_tag[READ_LAT-1] != NONE);
    assign o_rsrc   = r_tag[READ_LAT-1];

endmodule

// File: rtl/tcm_pmem_arb.sv
// Core/AXI arbiter for a single-port TCM with starvation guard for AXI.
// Build option TCM_PMEM_ARB_RR_EN: round-robin AXI write/read selection instead of write-first.
module tcm_pmem_arb
    import tcm_pmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 8192,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     core_req_i,
    input  logic                     core_wr_i,
    input  logic [ADDR_W-1:0]        core_addr_i,
    output logic                     core_accept_o,
    input  logic                     axi_awvalid_i,
    input  logic [ADDR_W-1:0]        axi_awaddr_i,
    output logic                     axi_awready_o,
    input  logic                     axi_arvalid_i,
    input  logic [ADDR_W-1:0]        axi_araddr_i,
    output logic                     axi_arready_o,
    output logic [$clog2(DEPTH)-1:0] mem_addr_o,
    output logic                     mem_wr_o,
    output logic                     mem_rd_o,
    output logic                     mem_rvalid_o,
    output logic [1:0]               mem_rsrc_o
);

    localparam int ADDR_LSB = $clog2(DATA_W / 8);
    localparam int MEM_AW   = $clog2(DEPTH);
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
        $error("tcm_pmem_arb: READ_LAT out of range");
    end
    if (STARVE_MAX < STARVE_MIN || STARVE_MAX > STARVE_MAX_LIM) begin : g_bad_starve_max
        $error("tcm_pmem_arb: STARVE_MAX out of range");
    end

    logic                    r_en;
    logic [STARVE_CNT_W-1:0] r_starve_cnt;
    logic [MEM_AW-1:0]       r_mem_addr;
    logic                    r_mem_wr;
    logic                    r_mem_rd;
    src_t                    r_rd_tag;
    logic                    w_any_axi;
    logic                    w_aw_first;
    logic                    w_gnt_core;
    logic                    w_gnt_aw;
    logic                    w_gnt_ar;
    logic                    w_gnt_axi;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic                    w_unused;
    src_t                    w_rsrc;

`ifdef TCM_PMEM_ARB_RR_EN
    logic r_rr_ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= 1'b0;
        end else if (w_gnt_axi) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end

    assign w_aw_first = ~r_rr_ptr;
`else
    assign w_aw_first = 1'b1;
`endif

    assign w_any_axi = axi_awvalid_i | axi_arvalid_i;
    assign w_gnt_axi = w_gnt_aw | w_gnt_ar;

    // r_en keeps the first cycle after reset release free of grants.
    always_comb begin
        w_gnt_core = 1'b0;
        w_gnt_aw   = 1'b0;
        w_gnt_ar   = 1'b0;
        w_sel_addr = core_addr_i;
        if (r_en) begin
            if (core_req_i && !(w_any_axi && (r_starve_cnt == STARVE_LIM))) begin
                w_gnt_core = 1'b1;
            end else if (axi_awvalid_i && (w_aw_first || !axi_arvalid_i)) begin
                w_gnt_aw   = 1'b1;
                w_sel_addr = axi_awaddr_i;
            end else if (axi_arvalid_i) begin
                w_gnt_ar   = 1'b1;
                w_sel_addr = axi_araddr_i;
            end
        end
    end

    assign core_accept_o = w_gnt_core;
    assign axi_awready_o = w_gnt_aw;
    assign axi_arready_o = w_gnt_ar;
    assign w_unused      = ^w_sel_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en         <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_en <= 1'b1;
            if (w_gnt_axi || !w_any_axi) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem_addr <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_rd_tag   <= NONE;
        end else begin
            r_mem_wr <= (w_gnt_core & core_wr_i) | w_gnt_aw;
            r_mem_rd <= (w_gnt_core & ~core_wr_i) | w_gnt_ar;
            r_rd_tag <= w_gnt_core ? CORE : AXI;
            if (w_gnt_core || w_gnt_axi) begin
                r_mem_addr <= w_sel_addr[ADDR_LSB +: MEM_AW];
            end
        end
    end

    tcm_pmem_rd_pipe #(
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_rd     (r_mem_rd),
        .i_tag    (r_rd_tag),
        .o_rvalid (mem_rvalid_o),
        .o_rsrc   (w_rsrc)
    );

    assign mem_addr_o = r_mem_addr;
    assign mem_wr_o   = r_mem_wr;
    assign mem_rd_o   = r_mem_rd;
    assign mem_rsrc_o = w_rsrc;

endmodule

// File: tb/tb_tcm_pmem_arb.sv
// Directed bench for tcm_pmem_arb at default parameters.
module tb_tcm_pmem_arb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_wr_i;
    logic [31:0] core_addr_i;
    logic        core_accept_o;
    logic        axi_awvalid_i;
    logic [31:0] axi_awaddr_i;
    logic        axi_awready_o;
    logic        axi_arvalid_i;
    logic [31:0] axi_araddr_i;
    logic        axi_arready_o;
    logic [12:0] mem_addr_o;
    logic        mem_wr_o, mem_rd_o, mem_rvalid_o;
    logic [1:0]  mem_rsrc_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    tcm_pmem_arb #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DEPTH      (8192),
        .READ_LAT   (1),
        .STARVE_MAX (7)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_req_i    (core_req_i),
        .core_wr_i     (core_wr_i),
        .core_addr_i   (core_addr_i),
        .core_accept_o (core_accept_o),
        .axi_awvalid_i (axi_awvalid_i),
        .axi_awaddr_i  (axi_awaddr_i),
        .axi_awready_o (axi_awready_o),
        .axi_arvalid_i (axi_arvalid_i),
        .axi_araddr_i  (axi_araddr_i),
        .axi_arready_o (axi_arready_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wr_o      (mem_wr_o),
        .mem_rd_o      (mem_rd_o),
        .mem_rvalid_o  (mem_rvalid_o),
        .mem_rsrc_o    (mem_rsrc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        chk("wr_rd_excl", 32'(mem_wr_o & mem_rd_o), 32'd0);
    endtask

    task automatic idle_inputs();
        core_req_i    = 1'b0;
        core_wr_i     = 1'b0;
        core_addr_i   = '0;
        axi_awvalid_i = 1'b0;
        axi_awaddr_i  = '0;
        axi_arvalid_i = 1'b0;
        axi_araddr_i  = '0;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;

        // Handshakes stay low under reset even with every source requesting.
        core_req_i = 1'b1; axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;
        #12;
        chk("rst_core_accept", 32'(core_accept_o), 32'd0);
        chk("rst_awready", 32'(axi_awready_o), 32'd0);
        chk("rst_arready", 32'(axi_arready_o), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_rvalid", 32'(mem_rvalid_o), 32'd0);
        idle_inputs();
        tick();
        rst_i = 1'b0;

        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_mem_rd", 32'(mem_rd_o), 32'd0);
            chk("idle_mem_wr", 32'(mem_wr_o), 32'd0);
            chk("idle_rvalid", 32'(mem_rvalid_o), 32'd0);
        end

        // Core read and AXI write collide: core first, AXI next cycle.
        core_req_i = 1'b1; core_wr_i = 1'b0; core_addr_i = 32'h0000_0010;
        axi_awvalid_i = 1'b1; axi_awaddr_i = 32'h0000_0020;
        #1;
        chk("col_core_accept", 32'(core_accept_o), 32'd1);
        chk("col_awready_lo", 32'(axi_awready_o), 32'd0);
        tick();
        chk("col_core_addr", 32'(mem_addr_o), 32'd4);
        chk("col_core_rd", 32'(mem_rd_o), 32'd1);
        chk("col_core_wr", 32'(mem_wr_o), 32'd0);
        core_req_i = 1'b0;
        #1;
        chk("col_awready_hi", 32'(axi_awready_o), 32'd1);
        tick();
        chk("col_axi_addr", 32'(mem_addr_o), 32'd8);
        chk("col_axi_wr", 32'(mem_wr_o), 32'd1);
        chk("col_axi_rd", 32'(mem_rd_o), 32'd0);
        chk("col_rvalid", 32'(mem_rvalid_o), 32'd1);
        chk("col_rsrc", 32'(mem_rsrc_o), 32'd1);
        idle_inputs();
        tick();
        chk("hold_addr", 32'(mem_addr_o), 32'd8);
        chk("hold_wr", 32'(mem_wr_o), 32'd0);
        chk("hold_rd", 32'(mem_rd_o), 32'd0);
        chk("hold_rvalid", 32'(mem_rvalid_o), 32'd0);

        // Starvation guard: AXI read wins on cycle STARVE_MAX+1.
        core_req_i = 1'b1; core_addr_i = 32'h0000_0000;
        axi_arvalid_i = 1'b1; axi_araddr_i = 32'h0000_0040;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk("starve_arready", 32'(axi_arready_o), (c == 8) ? 32'd1 : 32'd0);
            chk("starve_core_accept", 32'(core_accept_o), (c == 8) ? 32'd0 : 32'd1);
            tick();
        end
        chk("starve_axi_addr", 32'(mem_addr_o), 32'd16);
        chk("starve_axi_rd", 32'(mem_rd_o), 32'd1);
        idle_inputs();
        tick();
        chk("starve_rvalid", 32'(mem_rvalid_o), 32'd1);
        chk("starve_rsrc", 32'(mem_rsrc_o), 32'd2);

        // AXI write and read held together.
        axi_awvalid_i = 1'b1; axi_awaddr_i = 32'h0000_0080;
        axi_arvalid_i = 1'b1; axi_araddr_i = 32'h0000_00C0;
`ifdef TCM_PMEM_ARB_RR_EN
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_awready", 32'(axi_awready_o), (c % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_arready", 32'(axi_arready_o), (c % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
`else
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("fix_awready", 32'(axi_awready_o), 32'd1);
            chk("fix_arready", 32'(axi_arready_o), 32'd0);
            tick();
            chk("fix_mem_wr", 32'(mem_wr_o), 32'd1);
            chk("fix_mem_addr", 32'(mem_addr_o), 32'd32);
        end
`endif
        idle_inputs();
        tick();
        tick();

        // Address above DEPTH wraps.
        core_req_i = 1'b1; core_wr_i = 1'b1; core_addr_i = 32'h0000_8004;
        #1;
        chk("wrap_accept", 32'(core_accept_o), 32'd1);
        tick();
        chk("wrap_addr", 32'(mem_addr_o), 32'd1);
        chk("wrap_wr", 32'(mem_wr_o), 32'd1);
        idle_inputs();
        tick();

        // Reset pulse while an AXI read is in flight drops its return.
        axi_arvalid_i = 1'b1; axi_araddr_i = 32'h0000_0100;
        tick();
        chk("inflt_rd", 32'(mem_rd_o), 32'd1);
        idle_inputs();
        rst_i = 1'b1;
        #1;
        chk("inflt_rst_rd", 32'(mem_rd_o), 32'd0);
        chk("inflt_rst_rvalid", 32'(mem_rvalid_o), 32'd0);
        tick();
        chk("inflt_rst_rvalid2", 32'(mem_rvalid_o), 32'd0);
        rst_i = 1'b0;
        core_req_i = 1'b1;
        #1;
        chk("post_rst_no_grant", 32'(core_accept_o), 32'd0);
        core_req_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_rvalid", 32'(mem_rvalid_o), 32'd0);
            chk("post_rst_rd", 32'(mem_rd_o), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tcm_pmem_arb.md
TCM_PMEM_ARB -- requirements
Module: tcm_pmem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of all request ports.
REQ-002 SHALL have parameter DATA_W, default 32, memory word width; ADDR_LSB = clog2(DATA_W/8).
REQ-003 SHALL have parameter DEPTH, default 8192, memory words; MEM_AW = clog2(DEPTH).
REQ-004 SHALL have parameter READ_LAT, default 1, range 1..4, memory read latency in cycles.
REQ-005 SHALL have parameter STARVE_MAX, default 7, range 1..255, maximum consecutive cycles an AXI request may be denied.
REQ-006 SHALL have port clk_i  in  1  clock, rising edge.
REQ-007 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports core_req_i / core_wr_i  in  1 / 1  core request valid / write-not-read.
REQ-009 SHALL have ports core_addr_i  in  ADDR_W  core byte address; core_accept_o  out  1  core request granted this cycle.
REQ-010 SHALL have ports axi_awvalid_i  in  1; axi_awaddr_i  in  ADDR_W; axi_awready_o  out  1: AXI write address handshake.
REQ-011 SHALL have ports axi_arvalid_i  in  1; axi_araddr_i  in  ADDR_W; axi_arready_o  out  1: AXI read address handshake.
REQ-012 SHALL have ports mem_addr_o  out  MEM_AW; mem_wr_o  out  1; mem_rd_o  out  1: registered memory command.
REQ-013 SHALL have ports mem_rvalid_o  out  1; mem_rsrc_o  out  2: read-return strobe and source tag (01 core, 10 AXI).

Function
REQ-014 SHALL grant at most one source per cycle; grant is combinational from the current valids.
REQ-015 SHALL give priority core > AXI, except when starve_cnt == STARVE_MAX, where pending AXI wins over core.
REQ-016 SHALL arbitrate AXI write over AXI read when both are pending (fixed priority, macro absent).
REQ-017 SHALL assert core_accept_o, axi_awready_o or axi_arready_o only for the granted, valid source.
REQ-018 SHALL register the granted command: mem_addr_o = addr[ADDR_LSB+MEM_AW-1:ADDR_LSB] and mem_wr_o/mem_rd_o one cycle after grant.
REQ-019 SHALL truncate address bits above the memory range; addresses beyond DEPTH wrap modulo DEPTH.
REQ-020 SHALL drive mem_wr_o = mem_rd_o = 0 and hold mem_addr_o in any cycle after no grant.
REQ-021 SHALL never assert mem_wr_o and mem_rd_o together.
REQ-022 SHALL assert mem_rvalid_o with the matching tag exactly READ_LAT cycles after each mem_rd_o, via a tag shift pipeline; back-to-back reads are supported.
REQ-023 SHALL increment starve_cnt when an AXI valid is pending and not granted, saturating at STARVE_MAX; clear it on any AXI grant or when no AXI valid is pending.

Reset
REQ-024 SHALL, on rst_i, asynchronously clear mem_wr_o, mem_rd_o, mem_addr_o, mem_rvalid_o, mem_rsrc_o, starve_cnt, and the read pipeline.
REQ-025 SHALL reset every request-qualifying register to inactive (0); no read or write command may issue during or in the first cycle after reset.
REQ-026 SHALL discard in-flight read returns when reset is asserted mid-operation; no mem_rvalid_o follows reset release without a new mem_rd_o.
REQ-027 SHALL hold all handshake outputs at 0 while rst_i is asserted.

Configuration
REQ-028 SHALL support macro TCM_PMEM_ARB_RR_EN: when defined, AXI write vs read arbitration is round-robin with a 1-bit pointer reset to write, toggling after each AXI grant; when undefined, REQ-016 applies.

Structure
REQ-029 SHALL place the source-tag typedef (2-bit enum NONE/CORE/AXI) and range-check constants in package tcm_pmem_pkg.
REQ-030 SHALL implement the read-return tag pipeline as sub-module tcm_pmem_rd_pipe (parameter READ_LAT).

Verification
REQ-031 SHALL cover reset release with all valids at 0 and check that mem_rd_o/mem_wr_o stay 0 for 3 cycles and mem_rvalid_o never asserts.
REQ-032 SHALL cover core read 0x0000_0010 and AXI write 0x0000_0020 in the same cycle: core accepted; mem_addr_o=4 with mem_rd_o the next cycle; AXI accepted on the following cycle with mem_addr_o=8.
REQ-033 SHALL cover continuous core requests with axi_arvalid_i held: axi_arready_o asserts on cycle STARVE_MAX+1 (8 at default).
REQ-034 SHALL cover an AXI read issued, then rst_i pulsed for 1 cycle before READ_LAT elapses: no mem_rvalid_o is produced.
REQ-035 SHALL cover address 0x0000_8004 with DEPTH=8192: mem_addr_o=1 (wrap).
REQ-036 SHALL cover, with TCM_PMEM_ARB_RR_EN defined, aw and ar valids held together: grants alternate W, R, W, R.
